// File: rtl/sfifo_pkg.sv
// Shared defaults and pointer arithmetic for the sync_fifo_flags family.
package sfifo_pkg;

  localparam int unsigned SFIFO_WIDTH = 8;
  localparam int unsigned SFIFO_DEPTH = 8;

  // Occupancy from free-running pointers. The caller narrows the result to
  // AW+1 bits, which keeps the modular subtraction correct across wrap.
  function automatic logic [31:0] ptr_count(input logic [31:0] wptr,
                                            input logic [31:0] rptr);
    return wptr - rptr;
  endfunction

endpackage

// File: rtl/sfifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
module sfifo_mem
  import sfifo_pkg::*;
#(
  parameter  int unsigned WIDTH = SFIFO_WIDTH,
  parameter  int unsigned DEPTH = SFIFO_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; occupancy tracking makes stale
  // contents unreachable, and a reset here would defeat RAM inference.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with occupancy count, almost flags,
// sticky overflow/underflow and optional first-word-fall-through output.
module sync_fifo_flags
  import sfifo_pkg::*;
#(
  parameter  int unsigned WIDTH     = SFIFO_WIDTH,
  parameter  int unsigned DEPTH     = SFIFO_DEPTH,
  parameter  int unsigned AF_THRESH = DEPTH - 2,
  parameter  int unsigned AE_THRESH = 1,
  parameter  bit          FWFT      = 1'b0,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_wreq,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_rreq,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_almost_full,
  output logic             o_almost_empty,
  output logic [AW:0]      o_count,
  output logic             o_overflow,
  output logic             o_underflow
);

  logic [AW:0]      wptr, rptr;
  logic [AW:0]      wptr_nxt, rptr_nxt;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] rdata;

  // Acceptance uses the registered flags, so full+rd+wr refuses the write
  // and empty+rd+wr refuses the read.
  assign wr_acc   = i_wreq && !o_full;
  assign rd_acc   = i_rreq && !o_empty;
  assign wptr_nxt = wptr + (AW+1)'(wr_acc);
  assign rptr_nxt = rptr + (AW+1)'(rd_acc);

  sfifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr[AW-1:0]),
    .wdata (i_data),
    .raddr (rptr[AW-1:0]),
    .rdata (rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr        <= '0;
      rptr        <= '0;
      o_count     <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      wptr    <= wptr_nxt;
      rptr    <= rptr_nxt;
      o_count <= (AW+1)'(ptr_count(32'(wptr_nxt), 32'(rptr_nxt)));

      if (i_wreq && o_full)       o_overflow <= 1'b1;
      else if (i_clr_err)         o_overflow <= 1'b0;

      if (i_rreq && o_empty)      o_underflow <= 1'b1;
      else if (i_clr_err)         o_underflow <= 1'b0;
    end
  end

  assign o_empty        = (o_count == '0);
  assign o_full         = (32'(o_count) == DEPTH);
  assign o_almost_full  = (32'(o_count) >= AF_THRESH);
  assign o_almost_empty = (32'(o_count) <= AE_THRESH);

  generate
    if (FWFT) begin : g_fwft
      // Head entry shown directly; forced to zero while empty so stale
      // storage never leaks and reset reads back as zero.
      assign o_data = o_empty ? '0 : rdata;
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (!reset_n)    o_data <= '0;
        else if (rd_acc) o_data <= rdata;
      end
    end
  endgenerate

endmodule
